pulse_stretcher: RTL and testbench

//   Converse of the button one-pulser: turns single-cycle request pulses into

---
 rtl/dsd_pkg.sv | 27 ++
 rtl/pend_counter.sv | 42 ++++
 rtl/pulse_stretcher.sv | 134 +++++++++++++
 tb/tb_pulse_stretcher.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dsd_pkg.sv
// ============================================================================
// dsd_pkg : shared state encoding and sizing helpers for pulse_stretcher
// Rev 1.0
// ============================================================================
`default_nettype none

package dsd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int unsigned GAP_DEFAULT = 2;

  // The shared down-counter must hold both len-1 and GAP-1.
  function automatic int unsigned cnt_width(input int unsigned len_w,
                                            input int unsigned gap);
    int unsigned gap_w;
    gap_w = (gap > 1) ? $clog2(gap) : 1;
    return (len_w > gap_w) ? len_w : gap_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pend_counter.sv
// ============================================================================
// pend_counter : saturating up/down counter of queued requests
// Rev 1.0
// ============================================================================
`default_nettype none

module pend_counter #(
  parameter int unsigned PEND_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  input  logic              clr,
  output logic [PEND_W-1:0] count,
  output logic              full
);

  localparam logic [PEND_W-1:0] C_MAX = '1;

  logic [PEND_W-1:0] r_count;

  // inc and dec together cancel, so a request served from the queue in the
  // same cycle a new one arrives leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !dec && (r_count != C_MAX)) begin
      r_count <= r_count + 1'b1;
    end else if (dec && !inc && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count = r_count;
  assign full  = (r_count == C_MAX);

endmodule

`default_nettype wire

// File: rtl/pulse_stretcher.sv
// ============================================================================
// pulse_stretcher : turns request pulses into held levels of programmable
//                   length, with queueing/retrigger and a fixed low gap
// Rev 1.0
// ============================================================================
`default_nettype none

module pulse_stretcher
  import dsd_pkg::*;
#(
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned PEND_W = 4,
  parameter int unsigned GAP    = GAP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              pulse_in,
  input  logic [LEN_W-1:0]  len,
  input  logic              retrig,
  input  logic              clr_ovf,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int unsigned CNT_W = cnt_width(LEN_W, GAP);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_overflow;

  logic [LEN_W-1:0]   w_len_eff;
  logic [CNT_W-1:0]   w_hold_load;
  logic [CNT_W-1:0]   w_gap_load;
  logic               w_req;
  logic               w_pend_nz;
  logic               w_inc;
  logic               w_dec;
  logic               w_full;
  logic               w_ovf_evt;

  assign w_len_eff   = (len == '0) ? LEN_W'(1) : len;
  assign w_hold_load = CNT_W'(w_len_eff) - CNT_W'(1);
  assign w_gap_load  = CNT_W'(GAP - 1);
  assign w_req       = en & pulse_in;
  assign w_pend_nz   = (pending != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_inc       = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A queue that en=0 is clearing this cycle is not served.
        if (w_req || (en && w_pend_nz)) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = w_hold_load;
          w_dec       = en & w_pend_nz;
          w_inc       = w_req & w_pend_nz;
        end
      end
      ST_HOLD: begin
        w_inc = w_req & ~retrig;
        if (w_req && retrig) begin
          w_cnt_nxt = w_hold_load;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = w_gap_load;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_GAP: begin
        w_inc = w_req;
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  pend_counter #(
    .PEND_W (PEND_W)
  ) u_pend (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_inc),
    .dec   (w_dec),
    .clr   (~en),
    .count (pending),
    .full  (w_full)
  );

  // A request is lost only when it would have grown an already full queue.
  assign w_ovf_evt = w_inc & ~w_dec & w_full & en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_evt) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign level_out = (r_state == ST_HOLD);
  assign busy      = (r_state == ST_HOLD) || (r_state == ST_GAP);
  assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
// ============================================================================
// tb_pulse_stretcher : directed self-checking bench for pulse_stretcher
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       pulse_in;
  logic [7:0] len;
  logic       retrig;
  logic       clr_ovf;
  logic       level_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] r_lv;
  logic [63:0] r_bz;
  logic [63:0] r_pn;
  int          r_pv [64];

  pulse_stretcher #(
    .LEN_W  (8),
    .PEND_W (2),
    .GAP    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pulse_in  (pulse_in),
    .len       (len),
    .retrig    (retrig),
    .clr_ovf   (clr_ovf),
    .level_out (level_out),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle i samples outputs, and pulse_in=mask[i] is taken at the edge
  // closing cycle i.
  task automatic run(input int n, input logic [63:0] mask);
    r_lv = '0;
    r_bz = '0;
    r_pn = '0;
    for (int i = 0; i < n; i++) begin
      pulse_in = mask[i];
      r_lv[i]  = level_out;
      r_bz[i]  = busy;
      r_pn[i]  = (pending != 2'd0);
      r_pv[i]  = int'(pending);
      tick();
    end
    pulse_in = 1'b0;
  endtask

  initial begin
    int hi_cnt;
    rst      = 1'b1;
    en       = 1'b1;
    pulse_in = 1'b0;
    len      = 8'd3;
    retrig   = 1'b0;
    clr_ovf  = 1'b0;
    tick();
    check("rst_level",    64'(level_out), 64'd0);
    check("rst_busy",     64'(busy),      64'd0);
    check("rst_pending",  64'(pending),   64'd0);
    check("rst_overflow", 64'(overflow),  64'd0);
    rst = 1'b0;
    tick();

    // single pulse, len=3
    run(32, 64'h400);
    check("t1_level", r_lv, 64'h3800);
    check("t1_busy",  r_bz, 64'hF800);

    // two pulses queued
    run(32, 64'h1400);
    check("t2_level",   r_lv, 64'hE3800);
    check("t2_busy",    r_bz, 64'h3EF800);
    check("t2_pending", r_pn, 64'h1E000);

    // two pulses, retrigger extends hold
    retrig = 1'b1;
    run(32, 64'h1400);
    check("t3_level",   r_lv, 64'hF800);
    check("t3_busy",    r_bz, 64'h3F800);
    check("t3_pending", r_pn, 64'h0);
    retrig = 1'b0;

    // queue saturation and overflow
    len = 8'd4;
    run(40, 64'hFC);
    check("t4_level",     r_lv, 64'h0F1E3C78);
    check("t4_pend_c7",   64'(r_pv[7]),  64'd3);
    check("t4_pend_c10",  64'(r_pv[10]), 64'd2);
    check("t4_overflow",  64'(overflow), 64'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t4_clr_ovf",   64'(overflow), 64'd0);

    // len=0 behaves as 1
    len = 8'd0;
    run(16, 64'h2);
    check("t5_len0_level", r_lv, 64'h4);
    check("t5_len0_busy",  r_bz, 64'h1C);

    // len=255, len changed mid-hold ignored
    len      = 8'd255;
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    hi_cnt   = 0;
    for (int i = 0; i < 400; i++) begin
      if (level_out) hi_cnt++;
      if (i == 50) len = 8'd3;
      tick();
    end
    check("t5_len255_cycles", 64'(hi_cnt), 64'd255);

    // asynchronous reset mid-hold with queued work
    len = 8'd10;
    run(5, 64'hD);
    check("t6_pre_pending", 64'(pending),   64'd2);
    check("t6_pre_level",   64'(level_out), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_level",   64'(level_out), 64'd0);
    check("t6_rst_busy",    64'(busy),      64'd0);
    check("t6_rst_pending", 64'(pending),   64'd0);
    tick();
    rst = 1'b0;
    tick();

    // en=0 ignores pulses
    en = 1'b0;
    run(16, 64'h0F0F);
    check("t6_en0_level",   r_lv, 64'h0);
    check("t6_en0_busy",    r_bz, 64'h0);
    check("t6_en0_pending", r_pn, 64'h0);

    // en=0 mid-hold clears queue, hold finishes
    en = 1'b1;
    run(5, 64'hD);
    en = 1'b0;
    run(20, 64'h0);
    check("t6_drain_level",   r_lv, 64'h3F);
    check("t6_drain_pending", r_pn, 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
